// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared state type, window constants and window check for the store drain
package vram_pkg;

  typedef enum logic [2:0] {IDLE, POP, WAIT_SLOT, WRITE, RECOVER} drain_state_t;

  localparam logic [15:0] VRAM_BASE   = 16'h2000;
  localparam logic [15:0] VRAM_SIZE   = 16'h1000;
  localparam int          VRAM_ADDR_W = 12;

  // 17-bit compare so a window ending exactly at 0x10000 does not wrap to zero
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base = VRAM_BASE,
                                     input logic [15:0] size = VRAM_SIZE);
    logic [16:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/vram_store_drain.sv
// rtl/vram_store_drain.sv - drains the CPU store queue into the vector RAM write port
// Commits one store at a time, only in slots the vector generator leaves free.
module vram_store_drain
  import vram_pkg::*;
#(
  parameter logic [15:0] BASE         = VRAM_BASE,
  parameter logic [15:0] SIZE         = VRAM_SIZE,
  parameter int          ADDR_W       = VRAM_ADDR_W,
  parameter int          WR_CYCLES    = 2,
  parameter int          STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_empty,
  input  logic [7:0]        q_data,
  input  logic [15:0]       q_addr,
  output logic              q_pop,
  input  logic              mem_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              stall_req,
  output logic              idle,
  output logic [15:0]       wr_count,
  output logic [7:0]        drop_count
);

  localparam int            SW         = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    WR_LAST    = 4'(WR_CYCLES - 1);

  drain_state_t  state, state_nxt;
  logic [3:0]    wcnt;
  logic [SW-1:0] starve;
  logic          head_in_win;
  logic          wr_last;

  assign head_in_win = in_window(q_addr, BASE, SIZE);
  assign wr_last     = (wcnt == WR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!q_empty) state_nxt = POP;
      POP:       state_nxt = head_in_win ? WAIT_SLOT : IDLE;
      WAIT_SLOT: if (!mem_busy) state_nxt = WRITE;
      WRITE:     if (wr_last) state_nxt = RECOVER;
      RECOVER:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_pop     = (state == POP);
    mem_we    = (state == WRITE);
    idle      = (state == IDLE);
    stall_req = (starve >= STARVE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wcnt <= '0;
    else if (state == WRITE)
      wcnt <= wr_last ? 4'd0 : wcnt + 4'd1;
  end

  // The queue head is still valid during POP; it advances on the same edge we capture it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == POP && head_in_win) begin
      mem_addr  <= ADDR_W'(q_addr - BASE);
      mem_wdata <= q_data;
    end
  end

  sat_counter #(.W(16)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (state == WRITE && wr_last),
    .count (wr_count)
  );

  sat_counter #(.W(8)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (state == POP && !head_in_win),
    .count (drop_count)
  );

  sat_counter #(.W(SW)) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == WAIT_SLOT && !mem_busy),
    .inc   (state == WAIT_SLOT && mem_busy),
    .count (starve)
  );

endmodule

// File: tb/tb_vram_store_drain.sv
// tb/tb_vram_store_drain.sv - randomized self-checking bench for vram_store_drain
module tb_vram_store_drain;

  localparam int WR     = 2;
  localparam int LIM    = 64;
  localparam int BASE_I = 32'h2000;
  localparam int SIZE_I = 32'h1000;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        mem_busy = 1'b0;
  logic        q_empty;
  logic [7:0]  q_data;
  logic [15:0] q_addr;
  logic        q_pop;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        stall_req;
  logic        idle;
  logic [15:0] wr_count;
  logic [7:0]  drop_count;

  logic [15:0] qa [0:1023];
  logic [7:0]  qd [0:1023];
  int          head = 0;
  int          tail = 0;

  assign q_empty = (head == tail);
  assign q_addr  = qa[head[9:0]];
  assign q_data  = qd[head[9:0]];

  vram_store_drain #(
    .BASE(16'h2000), .SIZE(16'h1000), .ADDR_W(12), .WR_CYCLES(WR), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_data(q_data), .q_addr(q_addr),
    .q_pop(q_pop), .mem_busy(mem_busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .stall_req(stall_req), .idle(idle), .wr_count(wr_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // expectations for the coming cycle
  logic e_pop, e_wait, e_we, e_rec;
  int   wcnt, busy_seen, exp_wr, exp_drop;
  logic [11:0] c_addr;
  logic [7:0]  c_data;
  logic chk_en, pop_seen, prev_we;
  int   busy_mode;
  logic s_pop, s_we, s_stall;
  int   st_pops, st_we, st_nwr;
  logic [11:0] st_la [0:15];
  logic [7:0]  st_ld [0:15];

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic win(input logic [15:0] a);
    int v;
    v = int'(a);
    return (v >= BASE_I) && (v < BASE_I + SIZE_I);
  endfunction

  task automatic model_reset();
    e_pop = 0; e_wait = 0; e_we = 0; e_rec = 0;
    wcnt = 0; busy_seen = 0; exp_wr = 0; exp_drop = 0;
    c_addr = '0; c_data = '0; pop_seen = 0; prev_we = 0;
  endtask

  task automatic reset_stats();
    st_pops = 0; st_we = 0; st_nwr = 0;
  endtask

  task automatic model_check();
    logic exp_idle, exp_stall, n_pop, n_wait, n_we, n_rec;
    int   off;
    exp_idle  = !(e_pop || e_wait || e_we || e_rec);
    exp_stall = e_wait && (busy_seen >= LIM);
    chk("q_pop", int'(q_pop), int'(e_pop));
    chk("mem_we", int'(mem_we), int'(e_we));
    chk("idle", int'(idle), int'(exp_idle));
    chk("stall_req", int'(stall_req), int'(exp_stall));
    chk("wr_count", int'(wr_count), exp_wr);
    chk("drop_count", int'(drop_count), exp_drop);
    chk("pop_while_empty", int'(q_pop & q_empty), 0);
    if (e_we) begin
      chk("mem_addr", int'(mem_addr), int'(c_addr));
      chk("mem_wdata", int'(mem_wdata), int'(c_data));
    end
    s_pop = q_pop; s_we = mem_we; s_stall = stall_req; pop_seen = q_pop;
    st_pops += int'(q_pop);
    st_we   += int'(mem_we);
    if (mem_we && !prev_we) begin
      if (st_nwr < 16) begin st_la[st_nwr] = mem_addr; st_ld[st_nwr] = mem_wdata; end
      st_nwr++;
    end
    prev_we = mem_we;

    n_pop = 0; n_wait = 0; n_we = 0; n_rec = 0;
    if (e_pop) begin
      if (win(q_addr)) begin
        off = int'(q_addr) - BASE_I;
        c_addr = off[11:0]; c_data = q_data; n_wait = 1; busy_seen = 0;
      end else if (exp_drop < 255) exp_drop++;
    end
    if (e_wait) begin
      if (mem_busy) begin n_wait = 1; busy_seen++; end
      else begin n_we = 1; wcnt = 0; end
    end
    if (e_we) begin
      wcnt++;
      if (wcnt >= WR) begin n_rec = 1; if (exp_wr < 65535) exp_wr++; end
      else n_we = 1;
    end
    if (exp_idle && !q_empty) n_pop = 1;
    e_pop = n_pop; e_wait = n_wait; e_we = n_we; e_rec = n_rec;
  endtask

  task automatic drive_busy();
    case (busy_mode)
      0: mem_busy = 1'b0;
      1: mem_busy = 1'($urandom_range(0, 1));
      default: mem_busy = 1'b1;
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_en) model_check();
    @(posedge clk);
    #1;
    if (pop_seen && head != tail) head++;
    pop_seen = 1'b0;
    drive_busy();
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    qa[tail[9:0]] = a;
    qd[tail[9:0]] = d;
    tail++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(head == tail && !e_pop && !e_wait && !e_we && !e_rec)) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    compared++;
    if (n >= budget) begin
      mismatched++;
      $display("FAIL drain_timeout: used %0d cycles, budget %0d", n, budget);
    end
  endtask

  initial begin
    int n, first, r;
    logic hit;
    logic [15:0] a;
    chk_en = 0; busy_mode = 0;
    model_reset(); reset_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_pop", int'(q_pop), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_stall", int'(stall_req), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_wr_count", int'(wr_count), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    rst_n = 1; chk_en = 1;

    // single in-window store
    reset_stats(); push(16'h2010, 8'hA5); drain(50);
    chk("single_pops", st_pops, 1);
    chk("single_we_cycles", st_we, 2);
    chk("single_addr", int'(st_la[0]), 12'h010);
    chk("single_data", int'(st_ld[0]), 8'hA5);
    chk("single_wr_count", int'(wr_count), 1);
    chk("single_idle", int'(idle), 1);

    // both sides of the window
    reset_stats(); push(16'h1FFF, 8'h11); push(16'h3000, 8'h22); drain(50);
    chk("oow_pops", st_pops, 2);
    chk("oow_we_cycles", st_we, 0);
    chk("oow_drop_count", int'(drop_count), 2);
    chk("oow_wr_count", int'(wr_count), 1);

    // starvation
    reset_stats(); busy_mode = 2; mem_busy = 1; push(16'h2000, 8'h01);
    n = 0;
    s_pop = 0;
    while (!s_pop && n < 20) begin cycle(); n++; end
    first = -1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (s_stall && first < 0) first = i;
    end
    chk("starve_first_stall", first, 64);
    chk("starve_no_we", st_we, 0);
    busy_mode = 0; mem_busy = 0;
    cycle(); chk("release_c0_we", int'(s_we), 0);
    cycle(); chk("release_c1_we", int'(s_we), 1);
    chk("release_c1_stall", int'(s_stall), 0);
    drain(50);

    // back-to-back burst
    reset_stats();
    for (int i = 0; i < 4; i++) push(16'h2000 + 16'(i), 8'h10 + 8'(i));
    drain(100);
    chk("burst_pops", st_pops, 4);
    chk("burst_writes", st_nwr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_addr", int'(st_la[i]), i);
      chk("burst_data", int'(st_ld[i]), 8'h10 + i);
    end
    chk("burst_wr_count", int'(wr_count), 6);

    // randomized mix with random busy
    busy_mode = 1;
    for (int b = 0; b < 60; b++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        r = int'($urandom_range(0, 9));
        case (r)
          5: a = 16'h1FFF;
          6: a = 16'h3000;
          7: a = 16'h2FFF;
          8: a = 16'hFFFF;
          9: a = 16'($urandom);
          default: a = 16'h2000 + 16'($urandom_range(0, 12'hFFF));
        endcase
        push(a, 8'($urandom));
      end
      repeat (int'($urandom_range(0, 12))) cycle();
    end
    drain(8000);

    // drop counter saturation
    busy_mode = 0; reset_stats();
    for (int i = 0; i < 260; i++) push(16'h0100 + 16'(i), 8'(i));
    drain(2000);
    chk("sat_pops", st_pops, 260);
    chk("sat_drop_count", int'(drop_count), 8'hFF);

    // reset during the first write cycle
    reset_stats(); push(16'h2100, 8'h77);
    n = 0; hit = 0;
    while (n < 20 && !hit) begin
      @(negedge clk);
      model_check();
      if (mem_we) hit = 1;
      else begin
        @(posedge clk);
        #1;
        if (pop_seen && head != tail) head++;
        pop_seen = 1'b0;
      end
      n++;
    end
    compared++;
    if (!hit) begin mismatched++; $display("FAIL reset_wait: mem_we never rose within %0d cycles", n); end
    #1 rst_n = 0; chk_en = 0;
    #1;
    chk("arst_mem_we", int'(mem_we), 0);
    chk("arst_q_pop", int'(q_pop), 0);
    chk("arst_wr_count", int'(wr_count), 0);
    chk("arst_drop_count", int'(drop_count), 0);
    chk("arst_idle", int'(idle), 1);
    head = tail; pop_seen = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset(); chk_en = 1; reset_stats();
    repeat (20) cycle();
    chk("post_rst_we", st_we, 0);
    chk("post_rst_pops", st_pops, 0);
    push(16'h2ABC, 8'h5A); drain(50);
    chk("post_rst_addr", int'(st_la[0]), 12'hABC);
    chk("post_rst_data", int'(st_ld[0]), 8'h5A);
    chk("post_rst_wr_count", int'(wr_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
